// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares the uart_top transmitter between two word-wide
// requesters. Round-robin arbitration, one-cycle write strobe to the UART
// transmit address, then waits for the transmitter to finish (or time out)
// and inserts a short idle gap before the next grant.
module uart_tx_sched #(
   parameter logic [31:0] TX_ADDR    = 32'hFFFF_FFFF,
   parameter int unsigned START_WAIT = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [31:0] data0,
   output logic        ack0,
   input  logic        req1,
   input  logic [31:0] data1,
   output logic        ack1,
   input  logic        tx_busy,
   output logic        we,
   output logic [31:0] address,
   output logic [31:0] dataIn,
   output logic        grant_id,
   output logic        active,
   output logic [15:0] word_count
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] ISSUE      = 3'd1;
   localparam logic [2:0] WAIT_START = 3'd2;
   localparam logic [2:0] WAIT_DONE  = 3'd3;
   localparam logic [2:0] GAP        = 3'd4;

   localparam logic [3:0] WAIT_LAST  = 4'(START_WAIT - 1);
   localparam logic [3:0] GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
   localparam logic [2:0] AFTER_SEND = (GAP_CYCLES == 0) ? IDLE : GAP;

   logic [2:0] state;
   logic [2:0] nextState;
   logic       rr;
   logic [3:0] waitCnt;
   logic [3:0] gapCnt;
   logic       anyReq;
   logic       winner;
   logic       grantNow;

   // Pick the winner: a lone requester wins outright, a tie goes to rr
   always_comb begin
      anyReq   = req0 | req1;
      winner   = (req0 && req1) ? rr : req1;
      grantNow = (state == IDLE) && anyReq;
   end

   // Next-state decode for the issue / wait / gap sequence
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (anyReq) nextState = ISSUE;
         end
         ISSUE: begin
            nextState = WAIT_START;
         end
         WAIT_START: begin
            if (tx_busy) nextState = WAIT_DONE;
            else if (waitCnt == WAIT_LAST) nextState = AFTER_SEND;
         end
         WAIT_DONE: begin
            if (!tx_busy) nextState = AFTER_SEND;
         end
         GAP: begin
            if (gapCnt == GAP_LAST) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Start-wait counter: cleared while issuing, counts idle busy samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         waitCnt <= 4'd0;
      else if (state == ISSUE)
         waitCnt <= 4'd0;
      else if (state == WAIT_START && !tx_busy)
         waitCnt <= waitCnt + 4'd1;
   end

   // Gap counter: cleared on entry to GAP, counts gap cycles while in it
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         gapCnt <= 4'd0;
      else if (state != GAP)
         gapCnt <= 4'd0;
      else
         gapCnt <= gapCnt + 4'd1;
   end

   // Latch the granted word and move the round-robin pointer off the winner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dataIn   <= 32'd0;
         grant_id <= 1'b0;
         rr       <= 1'b0;
      end else if (grantNow) begin
         dataIn   <= winner ? data1 : data0;
         grant_id <= winner;
         rr       <= ~winner;
      end
   end

   // Strobe, address and ack are high exactly for the ISSUE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we      <= 1'b0;
         address <= 32'd0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
      end else begin
         we      <= grantNow;
         address <= grantNow ? TX_ADDR : 32'd0;
         ack0    <= grantNow && !winner;
         ack1    <= grantNow && winner;
      end
   end

   // Busy indication mirrors "not in IDLE" as a register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) active <= 1'b0;
      else       active <= (nextState != IDLE);
   end

   // Issued-word counter, bumped as ISSUE is left; wraps naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         word_count <= 16'd0;
      else if (state == ISSUE)
         word_count <= word_count + 16'd1;
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched. Stimulus pushes the
// expected grant into a queue; a monitor pops and checks on every strobe.
module tb_uart_tx_sched;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic [15:0] wc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req0;
   logic [31:0] data0;
   logic        ack0;
   logic        req1;
   logic [31:0] data1;
   logic        ack1;
   logic        tx_busy;
   logic        we;
   logic [31:0] address;
   logic [31:0] dataIn;
   logic        grant_id;
   logic        active;
   logic [15:0] word_count;

   exp_t        expQ[$];
   logic [15:0] expWc;
   int          checks;
   int          passes;
   int          strobeCount;
   int          busyDelay;
   int          busyLen;
   int          spacing;

   uart_tx_sched dut (
      .clk        (clk),
      .reset      (reset),
      .req0       (req0),
      .data0      (data0),
      .ack0       (ack0),
      .req1       (req1),
      .data1      (data1),
      .ack1       (ack1),
      .tx_busy    (tx_busy),
      .we         (we),
      .address    (address),
      .dataIn     (dataIn),
      .grant_id   (grant_id),
      .active     (active),
      .word_count (word_count)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual === required) passes++;
      else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
   endtask

   // Model of the transmitter: raise busy busyDelay edges after a strobe
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (we && busyLen > 0) begin
            repeat (busyDelay) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busyLen) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Monitor: every strobe pops one expected grant and checks it
   initial begin
      exp_t e;
      strobeCount = 0;
      forever begin
         @(negedge clk);
         if (!reset && we) begin
            strobeCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpected strobe", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("strobe grant_id", {31'd0, grant_id}, {31'd0, e.id});
               checkOutput("strobe dataIn", dataIn, e.data);
               checkOutput("strobe address", address, 32'hFFFF_FFFF);
               checkOutput("strobe ack0", {31'd0, ack0}, {31'd0, ~e.id});
               checkOutput("strobe ack1", {31'd0, ack1}, {31'd0, e.id});
               checkOutput("strobe word_count", {16'd0, word_count}, {16'd0, e.wc});
            end
         end else if (!reset && (ack0 || ack1 || address != 32'd0)) begin
            checkOutput("ack/address without strobe", {ack0, ack1, address[29:0]}, 32'd0);
         end
      end
   end

   task automatic pushExp(input logic id, input logic [31:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      e.wc   = expWc;
      expQ.push_back(e);
      expWc = expWc + 16'd1;
   endtask

   // One word from one requester, req dropped in the ack cycle
   task automatic applyStimulus(input logic id, input logic [31:0] d);
      int n = 0;
      pushExp(id, d);
      if (id) begin data1 = d; req1 = 1'b1; end
      else    begin data0 = d; req0 = 1'b1; end
      do begin
         @(negedge clk);
         n++;
      end while (!(id ? ack1 : ack0) && n < 200);
      checkOutput("ack within bound", {31'd0, (id ? ack1 : ack0)}, 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   // Hold requests until nWords acks are seen; report last ack spacing
   task automatic runHeld(input int nWords, input logic r0, input logic r1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          output int sp);
      int seen = 0;
      int n = 0;
      int tPrev = 0;
      int tLast = 0;
      data0 = d0;
      data1 = d1;
      req0  = r0;
      req1  = r1;
      while (seen < nWords && n < 2000) begin
         @(negedge clk);
         n++;
         if (ack0 || ack1) begin
            seen++;
            tPrev = tLast;
            tLast = n;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checkOutput("held words acked", seen, nWords);
      sp = tLast - tPrev;
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (active && n < limit);
      checkOutput("returned to idle", {31'd0, active}, 32'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expQ.delete();
      expWc = 16'd0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " we"}, {31'd0, we}, 32'd0);
      checkOutput({tag, " address"}, address, 32'd0);
      checkOutput({tag, " dataIn"}, dataIn, 32'd0);
      checkOutput({tag, " ack0"}, {31'd0, ack0}, 32'd0);
      checkOutput({tag, " ack1"}, {31'd0, ack1}, 32'd0);
      checkOutput({tag, " grant_id"}, {31'd0, grant_id}, 32'd0);
      checkOutput({tag, " active"}, {31'd0, active}, 32'd0);
      checkOutput({tag, " word_count"}, {16'd0, word_count}, 32'd0);
   endtask

   // Directed test sequence
   initial begin
      int n0;
      int n;
      checks    = 0;
      passes    = 0;
      expWc     = 16'd0;
      busyDelay = 2;
      busyLen   = 0;
      req0      = 1'b0;
      req1      = 1'b0;
      data0     = 32'd0;
      data1     = 32'd0;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1 checkResetValues("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single word with busy handshake
      $display("[TB] single word, busy handshake");
      busyLen = 20;
      n0 = strobeCount;
      applyStimulus(1'b0, 32'hAAAA_AAAA);
      waitIdle(100);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("single word strobe count", strobeCount - n0, 1);
      checkOutput("single word word_count", {16'd0, word_count}, 32'd1);
      // Held req0: busy rises 3 edges after issue, falls 20 later, 2 gap + idle
      pushExp(1'b0, 32'h1357_9BDF);
      pushExp(1'b0, 32'h1357_9BDF);
      runHeld(2, 1'b1, 1'b0, 32'h1357_9BDF, 32'd0, spacing);
      checkOutput("busy path strobe spacing", spacing, 26);
      waitIdle(100);

      // Both requesting continuously from reset
      $display("[TB] simultaneous requests");
      doReset();
      busyLen = 0;
      pushExp(1'b0, 32'h8765_4321);
      pushExp(1'b1, 32'h1E2D_3C4B);
      pushExp(1'b0, 32'h8765_4321);
      pushExp(1'b1, 32'h1E2D_3C4B);
      runHeld(4, 1'b1, 1'b1, 32'h8765_4321, 32'h1E2D_3C4B, spacing);
      checkOutput("alternating spacing", spacing, 8);
      waitIdle(50);

      // Timeout path, tx_busy never rises
      $display("[TB] timeout");
      pushExp(1'b1, 32'h0F0F_1234);
      pushExp(1'b1, 32'h0F0F_1234);
      runHeld(2, 1'b0, 1'b1, 32'd0, 32'h0F0F_1234, spacing);
      checkOutput("timeout strobe spacing", spacing, 8);
      waitIdle(50);

      // Reset in the middle of WAIT_DONE
      $display("[TB] reset during WAIT_DONE");
      busyLen = 20;
      applyStimulus(1'b0, 32'hDEAD_BEEF);
      repeat (8) @(posedge clk);
      #3 reset = 1'b1;
      #1 checkResetValues("async reset");
      busyLen = 0;
      n = 0;
      while (tx_busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("busy model released", {31'd0, tx_busy}, 32'd0);
      expQ.delete();
      expWc = 16'd0;
      pushExp(1'b0, 32'h5555_0000);
      pushExp(1'b1, 32'h0000_AAAA);
      data0 = 32'h5555_0000;
      data1 = 32'h0000_AAAA;
      req0  = 1'b1;
      req1  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      runHeld(2, 1'b1, 1'b1, 32'h5555_0000, 32'h0000_AAAA, spacing);
      waitIdle(50);

      // Counter wrap: preload the count just below the wrap point
      $display("[TB] counter wrap");
      force dut.word_count = 16'hFFFF;
      @(posedge clk);
      #1 release dut.word_count;
      expWc = 16'hFFFF;
      applyStimulus(1'b0, 32'h0BAD_F00D);
      waitIdle(50);
      checkOutput("wrap to zero", {16'd0, word_count}, 32'd0);
      applyStimulus(1'b1, 32'h1234_5678);
      waitIdle(50);
      checkOutput("wrap then one", {16'd0, word_count}, 32'd1);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
